// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable FIFO-buffered UART transmitter.
package uart_pkg;

    localparam int unsigned DATA_W_MIN = 5;
    localparam int unsigned DATA_W_MAX = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_mode_t;

    // Collapse the two parity control bits into one mode value.
    function automatic parity_mode_t par_mode(input logic en, input logic odd);
        if (!en) begin
            return PAR_NONE;
        end
        return odd ? PAR_ODD : PAR_EVEN;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with occupancy counter; pointers wrap modulo DEPTH.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = w_full;
    assign o_empty = w_empty;

    // Storage carries no reset; validity is tracked by the level counter.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with TX FIFO, runtime baud divisor and runtime frame format.
module uart_tx_fifo_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DIV_W  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [DATA_W-1:0]          i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [DIV_W-1:0]           i_div,
    input  logic                       i_parity_en,
    input  logic                       i_parity_odd,
    input  logic                       i_two_stop,
    output logic                       o_uart_tx,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned BIT_W = $clog2(DATA_W);

    generate
        if ((DATA_W < DATA_W_MIN) || (DATA_W > DATA_W_MAX)) begin : g_bad_data_w
            $error("uart_tx_fifo_cfg: DATA_W out of range");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_tx_fifo_cfg: DEPTH must be a power of two >= 2");
        end
    endgenerate

    tx_state_t          r_state;
    logic               r_tx;
    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_div_m1;
    logic [DATA_W-1:0]  r_shift;
    logic [BIT_W-1:0]   r_bit_idx;
    parity_mode_t       r_par_mode;
    logic               r_parity_bit;
    logic               r_two_stop;
    logic               r_stop2;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_fifo_data;
    logic [LVL_W-1:0]   w_level;
    logic [DIV_W-1:0]   w_div_m1;
    logic               w_bit_done;

    assign w_push     = i_valid & ~w_full;
    assign w_pop      = (r_state == IDLE) & ~w_empty;
    assign w_div_m1   = (i_div == '0) ? '0 : (i_div - DIV_W'(1));
    assign w_bit_done = (r_cnt == '0);

    assign o_ready   = ~w_full;
    assign o_level   = w_level;
    assign o_busy    = (r_state != IDLE) | ~w_empty;
    assign o_uart_tx = r_tx;

    uart_tx_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (i_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Serialiser: frame config is captured at the pop and held for the whole frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_tx         <= 1'b1;
            r_cnt        <= '0;
            r_div_m1     <= '0;
            r_shift      <= '0;
            r_bit_idx    <= '0;
            r_par_mode   <= PAR_NONE;
            r_parity_bit <= 1'b0;
            r_two_stop   <= 1'b0;
            r_stop2      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_state      <= START;
                        r_tx         <= 1'b0;
                        r_cnt        <= w_div_m1;
                        r_div_m1     <= w_div_m1;
                        r_shift      <= w_fifo_data;
                        r_par_mode   <= par_mode(i_parity_en, i_parity_odd);
                        r_parity_bit <= (^w_fifo_data) ^ i_parity_odd;
                        r_two_stop   <= i_two_stop;
                    end
                end

                START: begin
                    if (w_bit_done) begin
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_cnt     <= r_div_m1;
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end

                DATA: begin
                    if (w_bit_done) begin
                        r_cnt <= r_div_m1;
                        if (r_bit_idx == BIT_W'(DATA_W - 1)) begin
                            if (r_par_mode != PAR_NONE) begin
                                r_state <= PARITY;
                                r_tx    <= r_parity_bit;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                                r_stop2 <= 1'b0;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + BIT_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end

                PARITY: begin
                    if (w_bit_done) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                        r_stop2 <= 1'b0;
                        r_cnt   <= r_div_m1;
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end

                STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_done) begin
                        if (r_two_stop && !r_stop2) begin
                            r_stop2 <= 1'b1;
                            r_cnt   <= r_div_m1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Generalised UART transmitter with a parametrised transmit FIFO, a runtime baud divisor and runtime frame format (parity none/even/odd, 1 or 2 stop bits).
Accepts bytes over a valid/ready handshake and serialises them LSB-first on o_uart_tx.
Sits between the CPU-side peripheral register block and the board TX pin.
Successor to the fixed 8N1, single-buffer, compile-time-baud transmitter.

Parameters:
DATA_W, 8, payload bits per frame; legal 5..9.
DEPTH, 8, FIFO entries; power of two, >= 2.
DIV_W, 16, width of the runtime baud divisor.

Ports:
i_clk  in  1  sole clock.
i_rst_n  in  1  synchronous, active-low reset; sampled on the i_clk rising edge.
i_data  in  DATA_W  payload to enqueue.
i_valid  in  1  payload valid.
o_ready  out  1  FIFO can accept; push happens when i_valid & o_ready.
i_div  in  DIV_W  clocks per bit; 0 is treated as 1.
i_parity_en  in  1  append a parity bit.
i_parity_odd  in  1  1 = odd parity, 0 = even parity.
i_two_stop  in  1  2 stop bits when 1, else 1 stop bit.
o_uart_tx  out  1  serial line, registered, idles high.
o_busy  out  1  frame in progress or FIFO non-empty.
o_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (i_rst_n low at an edge):
  - FIFO emptied, so o_level=0 and o_ready=1.
  - FSM goes to IDLE, o_uart_tx=1, o_busy=0.
  - Applies mid-frame too: the line returns high on that edge and the partial frame is abandoned.
- o_ready = (o_level != DEPTH), combinational from the registered count.
- o_busy = (state != IDLE) | (o_level != 0).
- Push and pop in the same cycle: o_level is unchanged. A push into a full FIFO is not possible because o_ready=0.
- FSM states and transitions:
  - IDLE: line held at 1. When the FIFO is non-empty, pop the head and latch the frame config (data, divisor, parity_en, parity_odd, two_stop). Go to START.
  - START: line 0 for one bit time.
  - DATA: bits 0..DATA_W-1, LSB first, one bit time each.
  - PARITY: entered only if parity_en. Bit = XOR of the data bits, inverted when parity_odd.
  - STOP: line 1 for one bit time, or two bit times if two_stop. Then IDLE.
- Bit time: a down-counter reloads to div_latched-1 (0 if the divisor is 0) on each bit entry. The bit advances when the counter reaches 0. Each bit lasts exactly max(i_div,1) clocks.
- Config inputs are sampled only at the pop; changes mid-frame take effect on the next frame.
- Latency:
  - A push at edge N into an empty FIFO with the FSM in IDLE produces a pop at edge N+1, and o_uart_tx is 0 after edge N+1.
  - Back-to-back frames: the next start bit begins on the clock after the last stop-bit clock. There is exactly one IDLE cycle, which adds 1 clock of high line between frames.
- Frame length in clocks: div × (1 + DATA_W + parity_en + 1 + two_stop).
- Pointer arithmetic: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in a separate counter.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - constants for the legal DATA_W range;
  - the parity mode encoding.
- Sub-module uart_tx_fifo: a synchronous FIFO with push/pop/level and the same active-low sync reset.
- The serialiser FSM stays in the top module.

Test Plan:
- DATA_W=8, i_div=4, no parity, 1 stop; push 0xA5 -> line is 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, for a 40-clock frame; o_busy low 1 clock after the stop bit.
- Same byte with i_parity_en=1: even -> parity bit 0; odd -> parity bit 1; frame is 44 clocks.
- i_two_stop=1, i_div=0 -> each bit is 1 clock; 0x00 gives 0,0,0,0,0,0,0,0,0,1,1 (11 clocks).
- DEPTH=4, i_div=10; push 6 bytes in consecutive cycles ->
  - o_ready drops after the 5th push (one entry already popped);
  - o_level peaks at 4;
  - all 6 bytes are sent in order, with 1 idle clock between frames.
- Change i_div from 4 to 8 mid-frame -> the current frame stays at 4 clocks/bit and the next frame uses 8.
- Assert i_rst_n=0 during the 3rd data bit with 2 entries queued -> next edge: o_uart_tx=1, o_level=0, o_ready=1, o_busy=0; no further bits are sent after the reset is released.
